// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants for the VGA box renderer: horizontal/vertical timing
//   positions, active-area size, box geometry, colours and the encodings of
//   the box_motion state machine.
//   Optional build macro used by the renderer: VGA_BORDER_EN.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Timing positions, sized to match the 10-bit column/line counters
    localparam logic [9:0] H_TOTAL_M1  = 10'd794;
    localparam logic [9:0] H_ACT_START = 10'd140;
    localparam logic [9:0] H_ACT_END   = 10'd778;
    localparam logic [9:0] V_ACT_START = 10'd35;
    localparam logic [9:0] V_ACT_END   = 10'd515;
    localparam logic [9:0] V_TICK_LINE = 10'd516;   // first line of vertical blanking

    // Active area size (11 bits so box-edge sums never overflow)
    localparam logic [10:0] H_W = 11'd639;
    localparam logic [10:0] V_H = 11'd481;
    localparam logic [9:0]  H_W_M1 = 10'd638;
    localparam logic [9:0]  V_H_M1 = 10'd480;

    // Box geometry
    localparam logic [10:0] BOX_SIZE = 11'd32;
    localparam logic [10:0] STEP     = 11'd2;

    // Colours {R,G,B}
    localparam logic [23:0] BLACK = 24'h000000;
    localparam logic [23:0] WHITE = 24'hFFFFFF;
    localparam logic [23:0] BG    = 24'h0000FF;

    // box_motion FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MOVE_X = 2'd1;
    localparam logic [1:0] ST_MOVE_Y = 2'd2;

    // One axis of box motion: position plus direction (neg=1 means moving toward 0)
    typedef struct packed {
        logic       neg;
        logic [9:0] pos;
    } axis_t;

endpackage

// File: rtl/vga_box_renderer_box_motion.sv
// ---------------------------------------------------------------------------
// box_motion
//   Holds the box position (X, Y) and direction per axis. On a frame tick
//   with Run high it walks IDLE -> MOVE_X -> MOVE_Y -> IDLE, updating X then
//   Y by STEP and bouncing at the active-area edges. Ticks arriving outside
//   IDLE are ignored; once started, an update always completes.
// Ports:
//   Clock  in   pixel clock
//   Reset  in   synchronous, active-high; position 0,0, both directions +
//   tick   in   start-of-vertical-blanking strobe
//   Run    in   1 = motion enabled
//   X, Y   out  box top-left corner relative to the active area
// ---------------------------------------------------------------------------
module box_motion
    import vga_timing_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick,
    input  logic       Run,
    output logic [9:0] X,
    output logic [9:0] Y
);

    logic [1:0] state;
    axis_t      ax;
    axis_t      ay;

    // Advance one axis by STEP inside [0, span-BOX_SIZE], reversing at either edge
    function automatic axis_t step_axis(input axis_t a, input logic [10:0] span);
        axis_t       r;
        logic [10:0] pos11;
        logic [10:0] lim;
        logic [10:0] nxt;
        r     = a;
        pos11 = {1'b0, a.pos};
        lim   = span - BOX_SIZE;
        nxt   = '0;
        if (!a.neg) begin
            if (pos11 + BOX_SIZE + STEP > span) begin
                r.pos = lim[9:0];
                r.neg = 1'b1;
            end else begin
                nxt   = pos11 + STEP;
                r.pos = nxt[9:0];
            end
        end else begin
            if (pos11 < STEP) begin
                r.pos = '0;
                r.neg = 1'b0;
            end else begin
                nxt   = pos11 - STEP;
                r.pos = nxt[9:0];
            end
        end
        return r;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
            ax    <= '0;
            ay    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick && Run) state <= ST_MOVE_X;
                end
                ST_MOVE_X: begin
                    ax    <= step_axis(ax, H_W);
                    state <= ST_MOVE_Y;
                end
                ST_MOVE_Y: begin
                    ay    <= step_axis(ay, V_H);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign X = ax.pos;
    assign Y = ay.pos;

endmodule

// File: rtl/vga_box_renderer.sv
// ---------------------------------------------------------------------------
// vga_box_renderer
//   Pixel source for the VGA timing block. Given the current column/line
//   counters it produces the registered RGB for the next column, so the
//   output lines up with the timing block's counter when it appears. Draws a
//   bouncing BOX_SIZE square over a solid background; black outside the
//   active area. FrameTick pulses once per frame at the start of vertical
//   blanking.
//   Build macro VGA_BORDER_EN: when defined, a one-pixel white border is drawn
//   on the active-area edges, over the square.
// Ports:
//   Clock      in   pixel clock
//   Reset      in   synchronous, active-high
//   ColunaIn   in   [9:0]  current column counter
//   LinhaIn    in   [9:0]  current line counter
//   Run        in   1 = box motion enabled
//   BoxColor   in   [23:0] square colour {R,G,B}
//   RGB        out  [23:0] registered pixel colour {R,G,B}
//   FrameTick  out  registered one-cycle start-of-blanking pulse
// ---------------------------------------------------------------------------
module vga_box_renderer
    import vga_timing_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [9:0]  ColunaIn,
    input  logic [9:0]  LinhaIn,
    input  logic        Run,
    input  logic [23:0] BoxColor,
    output logic [23:0] RGB,
    output logic        FrameTick
);

    logic [9:0]  box_x;
    logic [9:0]  box_y;
    logic [9:0]  nc_p0;
    logic [9:0]  px_p0;
    logic [9:0]  py_p0;
    logic [10:0] px11;
    logic [10:0] py11;
    logic [10:0] bx11;
    logic [10:0] by11;
    logic        active_p0;
    logic        in_box_p0;
    logic        tick_p0;
    logic [23:0] rgb_p0;
`ifdef VGA_BORDER_EN
    logic        border_p0;
`endif
    logic [23:0] rgb_p1;
    logic        frame_tick_p1;

    box_motion u_motion (
        .Clock (Clock),
        .Reset (Reset),
        .tick  (tick_p0),
        .Run   (Run),
        .X     (box_x),
        .Y     (box_y)
    );

    // Stage p0: evaluate the pixel for the next column on the current line
    always_comb begin
        nc_p0     = (ColunaIn == H_TOTAL_M1) ? 10'd0 : ColunaIn + 10'd1;
        px_p0     = nc_p0 - H_ACT_START;
        py_p0     = LinhaIn - V_ACT_START;
        active_p0 = (nc_p0 >= H_ACT_START) && (nc_p0 <= H_ACT_END) &&
                    (LinhaIn >= V_ACT_START) && (LinhaIn <= V_ACT_END);
        px11      = {1'b0, px_p0};
        py11      = {1'b0, py_p0};
        bx11      = {1'b0, box_x};
        by11      = {1'b0, box_y};
        in_box_p0 = (px11 >= bx11) && (px11 < bx11 + BOX_SIZE) &&
                    (py11 >= by11) && (py11 < by11 + BOX_SIZE);
        tick_p0   = (LinhaIn == V_TICK_LINE) && (ColunaIn == 10'd0);
`ifdef VGA_BORDER_EN
        border_p0 = (px_p0 == 10'd0) || (px_p0 == H_W_M1) ||
                    (py_p0 == 10'd0) || (py_p0 == V_H_M1);
`endif
        if (!active_p0)
            rgb_p0 = BLACK;
`ifdef VGA_BORDER_EN
        else if (border_p0)
            rgb_p0 = WHITE;
`endif
        else if (in_box_p0)
            rgb_p0 = BoxColor;
        else
            rgb_p0 = BG;
    end

    // Stage p1: output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rgb_p1        <= BLACK;
            frame_tick_p1 <= 1'b0;
        end else begin
            rgb_p1        <= rgb_p0;
            frame_tick_p1 <= tick_p0;
        end
    end

    assign RGB       = rgb_p1;
    assign FrameTick = frame_tick_p1;

endmodule

// File: tb/tb_vga_box_renderer.sv
// ---------------------------------------------------------------------------
// tb_vga_box_renderer
//   Self-checking bench for vga_box_renderer. Drives column/line pairs
//   directly, keeps the box position and directions as plain integers and
//   derives every expected pixel colour from the drawing rules.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_box_renderer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  ColunaIn;
    logic [9:0]  LinhaIn;
    logic        Run;
    logic [23:0] BoxColor;
    logic [23:0] RGB;
    logic        FrameTick;

    vga_box_renderer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ColunaIn  (ColunaIn),
        .LinhaIn   (LinhaIn),
        .Run       (Run),
        .BoxColor  (BoxColor),
        .RGB       (RGB),
        .FrameTick (FrameTick)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference box state
    int mx = 0;
    int my = 0;
    bit mxneg = 1'b0;
    bit myneg = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [23:0] model_rgb(input int col, input int line, input logic [23:0] bc);
        int nc;
        int px;
        int py;
        nc = (col == 794) ? 0 : col + 1;
        if (nc < 140 || nc > 778 || line < 35 || line > 515) return 24'h000000;
        px = nc - 140;
        py = line - 35;
`ifdef VGA_BORDER_EN
        if (px == 0 || px == 638 || py == 0 || py == 480) return 24'hFFFFFF;
`endif
        if (px >= mx && px < mx + 32 && py >= my && py < my + 32) return bc;
        return 24'h0000FF;
    endfunction

    // Bounce rule on one axis with the given active span
    task automatic model_step(inout int p, inout bit neg, input int span);
        if (!neg) begin
            if (p + 32 + 2 > span) begin p = span - 32; neg = 1'b1; end
            else p = p + 2;
        end else begin
            if (p < 2) begin p = 0; neg = 1'b0; end
            else p = p - 2;
        end
    endtask

    task automatic probe(input string tag, input int col, input int line, input logic [23:0] bc);
        logic [23:0] exp;
        @(negedge Clock);
        ColunaIn = col[9:0];
        LinhaIn  = line[9:0];
        BoxColor = bc;
        exp      = model_rgb(col, line, bc);
        @(posedge Clock);
        #1;
        check(tag, 32'(RGB), 32'(exp));
    endtask

    // Probe by active-area coordinate (column fed in is one before the pixel)
    task automatic probe_px(input string tag, input int px, input int py, input logic [23:0] bc);
        int col;
        col = px + 140 - 1;
        if (col < 0) col = 794;
        probe(tag, col, py + 35, bc);
    endtask

    task automatic probe_box(input string tag);
        check({tag, "_x"}, 32'(dut.box_x), 32'(mx));
        check({tag, "_y"}, 32'(dut.box_y), 32'(my));
        probe_px({tag, "_tl"}, mx, my, 24'($urandom));
        probe_px({tag, "_br"}, mx + 31, my + 31, 24'($urandom));
        probe_px({tag, "_right"}, mx + 32, my + 5, 24'($urandom));
        probe_px({tag, "_below"}, mx + 5, my + 32, 24'($urandom));
        if (mx > 0) probe_px({tag, "_left"}, mx - 1, my + 5, 24'($urandom));
    endtask

    // One frame boundary: tick cycle, then enough cycles for the update to finish.
    // Run after the tick is random: a started update must complete regardless.
    task automatic frame(input bit run);
        @(negedge Clock);
        Run      = run;
        ColunaIn = 10'd0;
        LinhaIn  = 10'd516;
        @(posedge Clock);
        #1;
        check("frametick_pulse", 32'(FrameTick), 32'd1);
        @(negedge Clock);
        Run      = 1'($urandom);
        ColunaIn = 10'd1;
        @(posedge Clock);
        #1;
        check("frametick_low", 32'(FrameTick), 32'd0);
        @(negedge Clock);
        ColunaIn = 10'd2;
        LinhaIn  = 10'd517;
        @(negedge Clock);
        if (run) begin
            model_step(mx, mxneg, 639);
            model_step(my, myneg, 481);
        end
    endtask

    initial begin
        int    guard;
        int    sx;
        int    sy;
        Reset    = 1'b1;
        Run      = 1'b0;
        ColunaIn = 10'd139;
        LinhaIn  = 10'd35;
        BoxColor = 24'hABCDEF;

        // Reset held 3 cycles, with an active pixel and then a tick on the inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            if (i == 2) begin ColunaIn = 10'd0; LinhaIn = 10'd516; Run = 1'b1; end
            @(posedge Clock);
            #1;
            check("reset_rgb", 32'(RGB), 32'd0);
            check("reset_frametick", 32'(FrameTick), 32'd0);
        end
        @(negedge Clock);
        Reset = 1'b0;
        Run   = 1'b0;
        ColunaIn = 10'd5;
        LinhaIn  = 10'd520;
        @(negedge Clock);
        check("reset_x", 32'(dut.box_x), 32'd0);
        check("reset_y", 32'(dut.box_y), 32'd0);

        // First active pixel and the fixed-colour corner cases
        probe("first_active_pixel", 139, 35, 24'h123456);
        probe_px("px0_py0", 0, 0, 24'hFF0000);
        probe_px("px1_py1", 1, 1, 24'hFF0000);
        probe_px("px200_py200", 200, 200, 24'hFF0000);
        probe_px("px638_edge", 638, 100, 24'hFF0000);
        probe_px("py480_edge", 100, 480, 24'hFF0000);
        probe("wrap_col794", 794, 100, 24'hFF0000);
        probe("col778_outside", 778, 100, 24'hFF0000);
        probe("line34_outside", 200, 34, 24'hFF0000);
        probe("line516_outside", 200, 516, 24'hFF0000);
        probe_box("reset_box");

        // One frame with Run: X=2, Y=2
        frame(1'b1);
        check("frame1_x", 32'(dut.box_x), 32'd2);
        check("frame1_y", 32'(dut.box_y), 32'd2);
        probe_box("frame1");

        // Run until the model reaches X=606, with random probes along the way
        guard = 0;
        while (mx != 606 && guard < 400) begin
            frame(1'b1);
            guard++;
            if (guard % 25 == 0) begin
                probe_box("travel");
                for (int k = 0; k < 6; k++)
                    probe("random_pix", $urandom_range(0, 794), $urandom_range(0, 524), 24'($urandom));
            end
        end
        check("reach_606_bound", 32'(guard < 400), 32'd1);
        check("at_606", 32'(dut.box_x), 32'd606);
        frame(1'b1);
        check("bounce_607", 32'(dut.box_x), 32'd607);
        probe_box("right_edge");
        frame(1'b1);
        check("back_605", 32'(dut.box_x), 32'd605);

        // Run=0 for 3 frames: ticks still pulse, position frozen
        sx = mx;
        sy = my;
        for (int f = 0; f < 3; f++) frame(1'b0);
        check("frozen_x", 32'(dut.box_x), 32'(sx));
        check("frozen_y", 32'(dut.box_y), 32'(sy));

        // Random run/stop mix
        for (int f = 0; f < 40; f++) begin
            frame(1'($urandom));
            if (f % 8 == 0) probe_box("mix");
        end
        for (int k = 0; k < 20; k++)
            probe_px("near_box", mx + $urandom_range(0, 36) - 2, my + $urandom_range(0, 36) - 2,
                     24'($urandom));

        // Reset asserted while the update is in MOVE_X
        @(negedge Clock);
        Run      = 1'b1;
        ColunaIn = 10'd0;
        LinhaIn  = 10'd516;
        @(negedge Clock);
        Reset    = 1'b1;
        ColunaIn = 10'd1;
        @(posedge Clock);
        #1;
        check("midreset_x", 32'(dut.box_x), 32'd0);
        check("midreset_y", 32'(dut.box_y), 32'd0);
        check("midreset_rgb", 32'(RGB), 32'd0);
        @(negedge Clock);
        Reset = 1'b0;
        mx = 0; my = 0; mxneg = 1'b0; myneg = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("after_reset_idle_x", 32'(dut.box_x), 32'd0);
        frame(1'b1);
        check("after_reset_dx_pos", 32'(dut.box_x), 32'd2);
        check("after_reset_dy_pos", 32'(dut.box_y), 32'd2);
        probe_box("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
